// File: rtl/adder_pkg.sv
// Shared types for the pipelined add/subtract unit: operation encoding,
// per-stage control bookkeeping and the stage-count helper.
package adder_pkg;

  typedef enum logic {OP_ADD, OP_SUB} adder_op_e;

  // Control that travels alongside each slice's data through the pipeline.
  typedef struct packed {
    logic      vld;
    logic      carry;
    adder_op_e op;
  } stage_ctl_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational DATA_W-bit slice of the carry chain; also exposes the carry
// into its top bit so the final slice can derive signed overflow.
module adder_slice #(
  parameter int DATA_W = 4
) (
  input  logic              cin,
  input  logic [DATA_W-1:0] a_s,
  input  logic [DATA_W-1:0] b_s,
  output logic [DATA_W-1:0] s,
  output logic              cout,
  output logic              c_into_msb
);

  logic [DATA_W:0] full;

  assign full       = {1'b0, a_s} + {1'b0, b_s} + {{DATA_W{1'b0}}, cin};
  assign s          = full[DATA_W-1:0];
  assign cout       = full[DATA_W];
  // Sum bit = a ^ b ^ carry-in, so the carry into the top bit falls out directly.
  assign c_into_msb = s[DATA_W-1] ^ a_s[DATA_W-1] ^ b_s[DATA_W-1];

endmodule

// File: rtl/pipelined_nbit_adder.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit carry slice per stage, with a
// global valid/ready stall. Define ADDER_SATURATE_EN for unsigned clamping.
module pipelined_nbit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = ceil_div(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef ADDER_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_clamp(input logic [WIDTH-1:0] raw,
                                                 input logic cy, input adder_op_e op);
    if (op == OP_ADD && cy)  return '1;
    if (op == OP_SUB && !cy) return '0;
    return raw;
  endfunction
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int RW = WIDTH - LO;
    localparam int SW = (RW < CHUNK) ? RW : CHUNK;
    localparam int HI = LO + SW;

    // Operand bits not yet added, carry/op/valid, and the result so far.
    logic [RW-1:0] src_a;
    logic [RW-1:0] src_bx;
    stage_ctl_t    src_ctl;
    logic [SW-1:0] s_w;
    logic          c_w;
    logic          cmsb_w;
    logic [HI-1:0] sum_nxt;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_bx  = op_sub ? ~b : b;
      assign src_ctl = '{vld: in_valid, carry: op_sub, op: adder_op_e'(op_sub)};
      assign sum_nxt = s_w;
    end else begin : g_next
      assign src_a   = g_stage[k-1].g_mid.a_p;
      assign src_bx  = g_stage[k-1].g_mid.bx_p;
      assign src_ctl = g_stage[k-1].g_mid.ctl_p;
      assign sum_nxt = {s_w, g_stage[k-1].g_mid.s_p};
    end

    adder_slice #(.DATA_W(SW)) u_slice (
      .cin        (src_ctl.carry),
      .a_s        (src_a[SW-1:0]),
      .b_s        (src_bx[SW-1:0]),
      .s          (s_w),
      .cout       (c_w),
      .c_into_msb (cmsb_w)
    );

    if (k < LAST) begin : g_mid
      // ---- stage k register: skewed upper operand bits + partial sum ----
      logic [RW-SW-1:0] a_p;
      logic [RW-SW-1:0] bx_p;
      logic [HI-1:0]    s_p;
      stage_ctl_t       ctl_p;

      always_ff @(posedge clk) begin
        if (!rst_n)   ctl_p.vld <= 1'b0;
        else if (adv) ctl_p.vld <= src_ctl.vld;
        if (adv) begin
          ctl_p.carry <= c_w;
          ctl_p.op    <= src_ctl.op;
          a_p         <= src_a[RW-1:SW];
          bx_p        <= src_bx[RW-1:SW];
          s_p         <= sum_nxt;
        end
      end
    end else begin : g_last
      logic [WIDTH-1:0] sum_fin;

`ifdef ADDER_SATURATE_EN
      assign sum_fin = sat_clamp(sum_nxt, c_w, src_ctl.op);
`else
      logic unused_op;
      assign sum_fin   = sum_nxt;
      assign unused_op = (src_ctl.op == OP_SUB);
`endif

      // ---- final stage register: result and flags ----
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
        end else if (adv) begin
          out_valid <= src_ctl.vld;
          sum       <= sum_fin;
          cout      <= c_w;
          ovf       <= c_w ^ cmsb_w;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Directed bench for pipelined_nbit_adder: 8/4, 3/3 and 7/3 configurations,
// stall, reset-flush and exhaustive 7-bit coverage against a reference model.
module tb_pipelined_nbit_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  int         n_checks = 0;
  int         n_fail = 0;

  logic       in_valid, in_ready, op_sub, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;
  logic       in_valid3, in_ready3, op_sub3, out_valid3, out_ready3, cout3, ovf3;
  logic [2:0] a3, b3, sum3;
  logic       in_valid7, in_ready7, op_sub7, out_valid7, out_ready7, cout7, ovf7;
  logic [6:0] a7, b7, sum7;

  always #5 clk = ~clk;

  pipelined_nbit_adder #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_nbit_adder #(.WIDTH(3), .CHUNK(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
    .op_sub(op_sub3), .out_valid(out_valid3), .out_ready(out_ready3), .sum(sum3), .cout(cout3), .ovf(ovf3));

  pipelined_nbit_adder #(.WIDTH(7), .CHUNK(3)) u_w7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .a(a7), .b(b7),
    .op_sub(op_sub7), .out_valid(out_valid7), .out_ready(out_ready7), .sum(sum7), .cout(cout7), .ovf(ovf7));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum[7:0]} for a w-bit add or subtract.
  function automatic logic [9:0] ref_model(input int w, input int av, input int bv, input bit sub);
    int mask, bx, full, s, c, am, bm, sm, o;
    mask = (1 << w) - 1;
    bx   = sub ? (~bv & mask) : bv;
    full = av + bx + (sub ? 1 : 0);
    s    = full & mask;
    c    = (full >> w) & 1;
    am   = (av >> (w - 1)) & 1;
    bm   = (bx >> (w - 1)) & 1;
    sm   = (s >> (w - 1)) & 1;
    o    = (am == bm && sm != am) ? 1 : 0;
`ifdef ADDER_SATURATE_EN
    if (!sub && c == 1) s = mask;
    if (sub && c == 0)  s = 0;
`endif
    return {o[0], c[0], s[7:0]};
  endfunction

  task automatic run8(input string tag, input int av, input int bv, input bit sub,
                      input int es, input int ec, input int eo);
    @(negedge clk);
    in_valid = 1'b1; a = av[7:0]; b = bv[7:0]; op_sub = sub;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_lat"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_vld"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  task automatic run3(input string tag, input int av, input int bv, input int es, input int ec, input int eo);
    @(negedge clk);
    in_valid3 = 1'b1; a3 = av[2:0]; b3 = bv[2:0]; op_sub3 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid3 = 1'b0;
    check({tag, "_vld"}, out_valid3, 1);
    check({tag, "_sum"}, sum3, es);
    check({tag, "_cout"}, cout3, ec);
    check({tag, "_ovf"}, ovf3, eo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] q8[$];
    logic [9:0] q7[$];
    logic [9:0] e;
    logic [7:0] ta, tb, psum;
    logic       ts, pcout, povf, stall_prev;
    int         sent, rcvd, err7, got7;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; a3 = '0; b3 = '0; op_sub3 = 1'b0; out_ready3 = 1'b1;
    in_valid7 = 1'b0; a7 = '0; b7 = '0; op_sub7 = 1'b0; out_ready7 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // Directed add/sub vectors; the two clamp cases differ with saturation.
    run8("add_1_2", 1, 2, 1'b0, 3, 0, 0);
`ifdef ADDER_SATURATE_EN
    run8("add_200_100", 200, 100, 1'b0, 255, 1, 0);
    run8("sub_5_7", 5, 7, 1'b1, 0, 0, 0);
`else
    run8("add_200_100", 200, 100, 1'b0, 44, 1, 0);
    run8("sub_5_7", 5, 7, 1'b1, 254, 0, 0);
`endif
    run8("add_127_1", 127, 1, 1'b0, 128, 0, 1);
    run8("sub_128_1", 128, 1, 1'b1, 127, 1, 1);

    // Back-to-back stream of 16 ops with a downstream stall in cycles 3-6.
    sent = 0; rcvd = 0; stall_prev = 1'b0; psum = '0; pcout = 1'b0; povf = 1'b0;
    ta = 8'($urandom_range(0, 255)); tb = 8'($urandom_range(0, 255)); ts = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 16);
      a = ta; b = tb; op_sub = ts;
      #1;
      if (stall_prev) begin
        check("st_hold_vld", out_valid, 1);
        check("st_hold_sum", sum, psum);
        check("st_hold_flags", {cout, ovf}, {pcout, povf});
      end
      if (out_valid && !out_ready) check("st_in_ready", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q8.size() == 0) check("st_extra", 1, 0);
        else begin
          e = q8.pop_front();
          check("st_data", {ovf, cout, sum}, e);
        end
        rcvd++;
      end
      if (in_valid && in_ready) begin
        q8.push_back(ref_model(8, int'(ta), int'(tb), ts));
        sent++;
        ta = 8'($urandom_range(0, 255)); tb = 8'($urandom_range(0, 255)); ts = 1'($urandom_range(0, 1));
      end
      stall_prev = out_valid && !out_ready;
      psum = sum; pcout = cout; povf = ovf;
      if (sent == 16 && rcvd == 16) break;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("st_count", rcvd, 16);
    repeat (3) begin
      @(negedge clk);
      check("st_no_dup", out_valid, 0);
    end

    // Reset with two ops in flight flushes everything.
    @(negedge clk);
    in_valid = 1'b1; a = 8'd200; b = 8'd100; op_sub = 1'b0;
    @(negedge clk);
    a = 8'd127; b = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rf_pre_vld", out_valid, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rf_vld", out_valid, 0);
    check("rf_sum", sum, 0);
    check("rf_cout", cout, 0);
    check("rf_ovf", ovf, 0);
    check("rf_in_ready", in_ready, 1);
    repeat (4) begin
      @(negedge clk);
      check("rf_stale", out_valid, 0);
    end

    // Single-stage 3-bit configuration.
    run3("w3_3_3", 3, 3, 6, 0, 1);
    run3("w3_4_1", 4, 1, 5, 0, 0);

    // Exhaustive 7-bit add/sub through a 3-stage pipeline with a 1-bit last slice.
    err7 = 0; got7 = 0;
    for (int i = 0; i < 32768; i++) begin
      @(negedge clk);
      if (out_valid7) begin
        if (q7.size() == 0) err7++;
        else begin
          e = q7.pop_front();
          if ({ovf7, cout7, 1'b0, sum7} !== e) err7++;
        end
        got7++;
      end
      in_valid7 = 1'b1; a7 = i[6:0]; b7 = i[13:7]; op_sub7 = i[14];
      q7.push_back(ref_model(7, i & 127, (i >> 7) & 127, i[14]));
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      in_valid7 = 1'b0;
      if (out_valid7) begin
        if (q7.size() == 0) err7++;
        else begin
          e = q7.pop_front();
          if ({ovf7, cout7, 1'b0, sum7} !== e) err7++;
        end
        got7++;
      end
    end
    check("w7_errors", err7, 0);
    check("w7_count", got7, 32768);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
